pulse_stretcher: RTL and testbench



---
 rtl/pulse_stretcher_if.sv | 25 ++
 rtl/pulse_stretcher.sv | 106 ++++++++++
 tb/tb_pulse_stretcher.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// Event/indicator signal bundle for the two-channel pulse stretcher.
// The master drives events and the overflow clear; the slave returns the indicators.
interface pulse_stretcher_if;
    logic [1:0] inp;
    logic       ovf_clr;
    logic [1:0] outp;
    logic [1:0] busy;
    logic [1:0] ovf;

    modport master (
        output inp,
        output ovf_clr,
        input  outp,
        input  busy,
        input  ovf
    );

    modport slave (
        input  inp,
        input  ovf_clr,
        output outp,
        output busy,
        output ovf
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Two-channel event-to-LED stretcher: each event becomes a fixed-length flash followed by a
// fixed dark gap, with a bounded per-channel queue of pending events.
module pulse_stretcher #(
    parameter int unsigned STRETCH_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES     = 6250000,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned MAX_PEND       = 3,
    parameter int unsigned PEND_W         = 2
) (
    input logic              clk,
    input logic              clr,
    pulse_stretcher_if.slave bus
);

    localparam logic [CNT_W-1:0]  StretchLd = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GapLd     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax   = PEND_W'(MAX_PEND);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } state_e;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_e              state_q;
        logic [CNT_W-1:0]    cnt_q;
        logic [PEND_W-1:0]   pend_q;
        logic                outp_q;
        logic                busy_q;
        logic                ovf_q;

        logic ev;
        logic last;
        logic queue_ev;
        logic drop;

        // An event on the final GAP cycle starts the next flash directly instead of queueing.
        always_comb begin
            ev       = bus.inp[i];
            last     = (cnt_q == '0);
            queue_ev = ev && ((state_q == StOn) || ((state_q == StGap) && !last));
            drop     = queue_ev && (pend_q == PendMax);
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pend_q  <= '0;
                outp_q  <= 1'b0;
                busy_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                ovf_q <= drop | (ovf_q & ~bus.ovf_clr);
                if (queue_ev && !drop) begin
                    pend_q <= pend_q + 1'b1;
                end
                unique case (state_q)
                    StIdle: begin
                        if (ev) begin
                            state_q <= StOn;
                            cnt_q   <= StretchLd;
                            outp_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    StOn: begin
                        if (last) begin
                            state_q <= StGap;
                            cnt_q   <= GapLd;
                            outp_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StGap: begin
                        if (!last) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (ev || (pend_q != '0)) begin
                            state_q <= StOn;
                            cnt_q   <= StretchLd;
                            outp_q  <= 1'b1;
                            if (!ev) begin
                                pend_q <= pend_q - 1'b1;
                            end
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        outp_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.outp[i] = outp_q;
        assign bus.busy[i] = busy_q;
        assign bus.ovf[i]  = ovf_q;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: expected indicator vectors are queued as stimulus is
// driven and compared one cycle later, after the sampling edge.
module tb_pulse_stretcher;

    logic clk;
    logic clr;

    pulse_stretcher_if bus ();

    pulse_stretcher #(
        .STRETCH_CYCLES(4),
        .GAP_CYCLES    (2),
        .CNT_W         (4),
        .MAX_PEND      (3),
        .PEND_W        (2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] outp;
        logic [1:0] busy;
        logic [1:0] ovf;
        int         sc;
        int         k;
    } exp_t;

    exp_t sb[$];
    int   nassert = 0;
    int   nfail   = 0;

    // Flash started at sample s: high for 4 samples.
    function automatic logic fl(input int k, input int s);
        return (k >= s) && (k < s + 4);
    endfunction

    function automatic logic win(input int k, input int s, input int n);
        return (k >= s) && (k < s + n);
    endfunction

    task automatic push(input logic [1:0] o, input logic [1:0] b, input logic [1:0] v,
                        input int sc, input int k);
        exp_t e;
        e.outp = o;
        e.busy = b;
        e.ovf  = v;
        e.sc   = sc;
        e.k    = k;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            nassert++;
            nfail++;
            $error("FAIL sb_empty: got no expected entry, want one");
            return;
        end
        e = sb.pop_front();
        nassert++;
        assert (bus.outp === e.outp) else begin
            nfail++;
            $error("FAIL s%0d k%0d outp: got %b want %b", e.sc, e.k, bus.outp, e.outp);
        end
        nassert++;
        assert (bus.busy === e.busy) else begin
            nfail++;
            $error("FAIL s%0d k%0d busy: got %b want %b", e.sc, e.k, bus.busy, e.busy);
        end
        nassert++;
        assert (bus.ovf === e.ovf) else begin
            nfail++;
            $error("FAIL s%0d k%0d ovf: got %b want %b", e.sc, e.k, bus.ovf, e.ovf);
        end
    endtask

    task automatic cyc(input logic [1:0] in, input logic [1:0] o, input logic [1:0] b,
                       input logic [1:0] v, input int sc, input int k);
        bus.inp = in;
        push(o, b, v, sc, k);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        clr         = 1'b0;
        bus.inp     = 2'b00;
        bus.ovf_clr = 1'b0;

        // 1: asynchronous reset with inputs active
        #2 clr = 1'b1;
        #1;
        push(2'b00, 2'b00, 2'b00, 1, 0);
        check_now();
        for (int k = 1; k <= 3; k++) cyc(2'b11, 2'b00, 2'b00, 2'b00, 1, k);
        #3;
        bus.inp = 2'b00;
        clr     = 1'b0;
        for (int k = 4; k <= 7; k++) cyc(2'b00, 2'b00, 2'b00, 2'b00, 1, k);

        // 2: single pulse on channel 0
        for (int k = 0; k < 10; k++)
            cyc((k == 0) ? 2'b01 : 2'b00, {1'b0, fl(k, 0)}, {1'b0, win(k, 0, 6)}, 2'b00, 2, k);

        // 3: level held three cycles -> three back-to-back flashes
        for (int k = 0; k < 22; k++)
            cyc({1'b0, (k < 3)}, {1'b0, fl(k, 0) | fl(k, 6) | fl(k, 12)},
                {1'b0, win(k, 0, 18)}, 2'b00, 3, k);

        // 4: six pulses -> saturation, two drops, four flashes, sticky ovf
        for (int k = 0; k < 28; k++)
            cyc({1'b0, (k < 6)}, {1'b0, fl(k, 0) | fl(k, 6) | fl(k, 12) | fl(k, 18)},
                {1'b0, win(k, 0, 24)}, {1'b0, (k >= 4)}, 4, k);
        bus.ovf_clr = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 4, 28);
        bus.ovf_clr = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 4, 29);

        // 5: ch1 event on its final gap cycle; ch0 runs independently
        for (int k = 0; k < 16; k++)
            cyc({(k == 0) || (k == 6), (k == 2) || (k == 3)},
                {fl(k, 0) | fl(k, 6), fl(k, 2) | fl(k, 8)},
                {win(k, 0, 12), win(k, 2, 12)}, 2'b00, 5, k);

        // 7: ovf_clr coincides with a drop -> drop wins
        for (int k = 0; k < 27; k++) begin
            bus.ovf_clr = (k == 4);
            cyc({1'b0, (k < 5)}, {1'b0, fl(k, 0) | fl(k, 6) | fl(k, 12) | fl(k, 18)},
                {1'b0, win(k, 0, 24)}, {1'b0, (k >= 4)}, 7, k);
        end
        bus.ovf_clr = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 7, 27);
        bus.ovf_clr = 1'b0;

        // 6: async clear mid-ON with ch0 pending=2 and ch1 ovf set
        for (int k = 0; k < 5; k++)
            cyc({(k < 5), (k >= 2)}, {fl(k, 0), fl(k, 2)}, {win(k, 0, 6), win(k, 2, 6)},
                {(k >= 4), 1'b0}, 6, k);
        bus.inp = 2'b00;
        #3 clr = 1'b1;
        #1;
        push(2'b00, 2'b00, 2'b00, 6, 5);
        check_now();
        for (int k = 6; k < 8; k++) cyc(2'b00, 2'b00, 2'b00, 2'b00, 6, k);
        #3 clr = 1'b0;
        for (int k = 8; k < 28; k++) cyc(2'b00, 2'b00, 2'b00, 2'b00, 6, k);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
